// File: rtl/uart_rx_cfg_if.sv
// Receive-side bundle of the configurable UART receiver.
// The receiver drives it through the master modport; downstream logic reads it through the slave modport.
interface uart_rx_cfg_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] o_data;
  logic               o_valid;
  logic               o_parity_err;
  logic               o_frame_err;
  logic               o_busy;

  modport master (
    output o_data,
    output o_valid,
    output o_parity_err,
    output o_frame_err,
    output o_busy
  );

  modport slave (
    input o_data,
    input o_valid,
    input o_parity_err,
    input o_frame_err,
    input o_busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampled UART receiver: configurable width, parity and stop bits.
// Uses 3-sample majority voting and recovers from a break through a wait-for-idle state.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int N_TICKS    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int NB_STOP    = 1
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_tick,
  input  logic           i_rx_data,
  uart_rx_cfg_if.master  rx_if
);

  localparam int TW = $clog2(N_TICKS);
  localparam int BW = $clog2(NB_DATA + 1);

  localparam logic [TW-1:0] CNT_HALF = TW'(N_TICKS / 2 - 1);
  localparam logic [TW-1:0] CNT_S0   = TW'(N_TICKS - 3);
  localparam logic [TW-1:0] CNT_S1   = TW'(N_TICKS - 2);
  localparam logic [TW-1:0] CNT_LAST = TW'(N_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(NB_DATA - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(NB_STOP - 1);
  localparam logic          ODD_PAR   = (PARITY_ODD != 0);
  localparam logic          HAS_PAR   = (PARITY_EN != 0);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_DONE      = 3'd5;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

  logic [1:0]         sync_reg;
  logic               rx_sync;
  logic [2:0]         state_reg,  state_next;
  logic [TW-1:0]      cnt_reg,    cnt_next;
  logic [BW-1:0]      bit_reg,    bit_next;
  logic [NB_DATA-1:0] shift_reg,  shift_next;
  logic [NB_DATA-1:0] data_reg,   data_next;
  logic [1:0]         samp_reg,   samp_next;
  logic               perr_reg,   perr_next;
  logic               ferr_reg,   ferr_next;
  logic               sampling;
  logic               bit_done;
  logic               bit_val;

  // Two-flop synchroniser; it resets to the idle (high) line level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], i_rx_data};
    end
  end

  assign rx_sync = sync_reg[1];

  assign sampling = (state_reg == ST_DATA) || (state_reg == ST_PARITY) ||
                    (state_reg == ST_STOP);
  assign bit_done = sampling && i_tick && (cnt_reg == CNT_LAST);
  // The third vote is the live sample taken on the resolving tick itself.
  assign bit_val  = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx_sync) |
                    (samp_reg[1] & rx_sync);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    samp_next  = samp_reg;
    perr_next  = perr_reg;
    ferr_next  = ferr_reg;

    if (sampling && i_tick) begin
      if (cnt_reg == CNT_S0) samp_next[0] = rx_sync;
      if (cnt_reg == CNT_S1) samp_next[1] = rx_sync;
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + TW'(1);
    end

    if (state_reg == ST_DONE) begin
      state_next = ferr_reg ? ST_WAIT_IDLE : ST_IDLE;
    end else if (i_tick) begin
      case (state_reg)
        ST_IDLE: begin
          if (!rx_sync) begin
            state_next = ST_START;
            cnt_next   = '0;
            bit_next   = '0;
            perr_next  = 1'b0;
            ferr_next  = 1'b0;
          end
        end
        ST_START: begin
          if (cnt_reg == CNT_HALF) begin
            cnt_next   = '0;
            state_next = rx_sync ? ST_IDLE : ST_DATA;
          end else begin
            cnt_next = cnt_reg + TW'(1);
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            shift_next = {bit_val, shift_reg[NB_DATA-1:1]};
            if (bit_reg == BIT_LAST) begin
              bit_next   = '0;
              state_next = HAS_PAR ? ST_PARITY : ST_STOP;
            end else begin
              bit_next = bit_reg + BW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            if (bit_val != ((^shift_reg) ^ ODD_PAR)) perr_next = 1'b1;
            state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            // A low stop bit ends the frame at once; remaining stop bits are not awaited.
            if (!bit_val) begin
              ferr_next  = 1'b1;
              data_next  = shift_reg;
              state_next = ST_DONE;
            end else if (bit_reg == STOP_LAST) begin
              data_next  = shift_reg;
              state_next = ST_DONE;
            end else begin
              bit_next = bit_reg + BW'(1);
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (rx_sync) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      samp_reg  <= '0;
      perr_reg  <= 1'b0;
      ferr_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      samp_reg  <= samp_next;
      perr_reg  <= perr_next;
      ferr_reg  <= ferr_next;
    end
  end

  assign rx_if.o_data       = data_reg;
  assign rx_if.o_valid      = (state_reg == ST_DONE);
  assign rx_if.o_parity_err = (state_reg == ST_DONE) && perr_reg;
  assign rx_if.o_frame_err  = (state_reg == ST_DONE) && ferr_reg;
  assign rx_if.o_busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 8E1, 7N2) share clock, tick and reset.
// Frames come from a vector table plus hand-written break, glitch and reset sequences.
module tb_uart_rx_cfg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [2:0] rx = 3'b111;
  int         tick_cnt = 0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // One tick every 4 clocks, updated away from the active edge.
  always @(negedge clk) begin
    tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
    tick     = (tick_cnt == 3);
  end

  uart_rx_cfg_if #(.NB_DATA(8)) if_def ();
  uart_rx_cfg_if #(.NB_DATA(8)) if_par ();
  uart_rx_cfg_if #(.NB_DATA(7)) if_72 ();

  uart_rx_cfg #(.NB_DATA(8), .N_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(1)) u_def (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_rx_data(rx[0]), .rx_if(if_def.master));
  uart_rx_cfg #(.NB_DATA(8), .N_TICKS(16), .PARITY_EN(1), .PARITY_ODD(0), .NB_STOP(1)) u_par (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_rx_data(rx[1]), .rx_if(if_par.master));
  uart_rx_cfg #(.NB_DATA(7), .N_TICKS(16), .PARITY_EN(0), .PARITY_ODD(0), .NB_STOP(2)) u_72 (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_rx_data(rx[2]), .rx_if(if_72.master));

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  frame_t cap_q[$];
  frame_t exp_q[$];

  always @(negedge clk) begin
    if (if_def.o_valid) cap_q.push_back('{0, {1'b0, if_def.o_data}, if_def.o_parity_err, if_def.o_frame_err});
    if (if_par.o_valid) cap_q.push_back('{1, {1'b0, if_par.o_data}, if_par.o_parity_err, if_par.o_frame_err});
    if (if_72.o_valid)  cap_q.push_back('{2, {2'b00, if_72.o_data}, if_72.o_parity_err, if_72.o_frame_err});
  end

  typedef struct {
    int         dut;
    logic [8:0] word;
    logic       par_bit;
    logic       stop1;
    logic       stop2;
    int         glitch_bit;
    int         gap;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (tick) k++;
    end
    @(negedge clk);
  endtask

  task automatic drive(input int d, input logic v, input int nticks);
    rx[d] = v;
    wait_ticks(nticks);
  endtask

  task automatic send_frame(input int d, input logic [8:0] w, input logic par_bit,
                            input logic stop1, input logic stop2, input int glitch_bit);
    int nbits = (d == 2) ? 7 : 8;
    drive(d, 1'b0, 16);
    for (int i = 0; i < nbits; i++) begin
      if (i == glitch_bit) begin
        drive(d, w[i], 7);
        drive(d, ~w[i], 1);
        drive(d, w[i], 8);
      end else begin
        drive(d, w[i], 16);
      end
    end
    if (d == 1) drive(d, par_bit, 16);
    drive(d, stop1, 16);
    if (d == 2) drive(d, stop2, 16);
  endtask

  task automatic check_pending(input string name);
    frame_t c, e;
    chk({name, " frames"}, 9'(cap_q.size()), 9'(exp_q.size()));
    while (cap_q.size() > 0 && exp_q.size() > 0) begin
      c = cap_q.pop_front();
      e = exp_q.pop_front();
      chk({name, " dut"},  9'(c.dut), 9'(e.dut));
      chk({name, " data"}, c.data, e.data);
      chk({name, " perr"}, {8'd0, c.perr}, {8'd0, e.perr});
      chk({name, " ferr"}, {8'd0, c.ferr}, {8'd0, e.ferr});
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //            dut word    par   s1    s2   glt gap exp     perr  ferr
    vecs[0]  = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, -1, 0, 9'h0A5, 1'b0, 1'b0};
    vecs[1]  = '{0, 9'h03C, 1'b0, 1'b1, 1'b1, -1, 2, 9'h03C, 1'b0, 1'b0};
    vecs[2]  = '{1, 9'h055, 1'b0, 1'b1, 1'b1, -1, 2, 9'h055, 1'b0, 1'b0};
    vecs[3]  = '{1, 9'h055, 1'b1, 1'b1, 1'b1, -1, 2, 9'h055, 1'b1, 1'b0};
    vecs[4]  = '{0, 9'h00F, 1'b0, 1'b1, 1'b1,  2, 2, 9'h00F, 1'b0, 1'b0};
    vecs[5]  = '{2, 9'h05A, 1'b0, 1'b1, 1'b0, -1, 2, 9'h05A, 1'b0, 1'b1};
    vecs[6]  = '{0, 9'h000, 1'b0, 1'b1, 1'b1, -1, 2, 9'h000, 1'b0, 1'b0};
    vecs[7]  = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1,  5, 2, 9'h0FF, 1'b0, 1'b0};
    vecs[8]  = '{1, 9'h001, 1'b1, 1'b1, 1'b1, -1, 2, 9'h001, 1'b0, 1'b0};
    vecs[9]  = '{1, 9'h080, 1'b0, 1'b1, 1'b1, -1, 2, 9'h080, 1'b1, 1'b0};
    vecs[10] = '{2, 9'h07F, 1'b0, 1'b1, 1'b1, -1, 2, 9'h07F, 1'b0, 1'b0};
    vecs[11] = '{0, 9'h012, 1'b0, 1'b0, 1'b1, -1, 2, 9'h012, 1'b0, 1'b1};
    vecs[12] = '{2, 9'h033, 1'b0, 1'b0, 1'b1, -1, 2, 9'h033, 1'b0, 1'b1};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    chk("reset data",  {1'b0, if_def.o_data}, 9'h000);
    chk("reset valid", {8'd0, if_def.o_valid}, 9'd0);
    chk("reset perr",  {8'd0, if_par.o_parity_err}, 9'd0);
    chk("reset ferr",  {8'd0, if_def.o_frame_err}, 9'd0);
    chk("reset busy",  {6'd0, if_def.o_busy, if_par.o_busy, if_72.o_busy}, 9'd0);
    wait_ticks(8);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      send_frame(v.dut, v.word, v.par_bit, v.stop1, v.stop2, v.glitch_bit);
      exp_q.push_back('{v.dut, v.exp_data, v.exp_perr, v.exp_ferr});
      if (v.gap > 0) begin
        drive(v.dut, 1'b1, 16 * v.gap);
        check_pending($sformatf("vec%0d", i));
        $display("vec%0d dut%0d word %0h done", i, v.dut, v.word);
      end
    end
    chk("data hold", {1'b0, if_def.o_data}, 9'h012);

    // Short low glitch on an idle line: false start, nothing delivered.
    drive(0, 1'b0, 3);
    chk("glitch busy", {8'd0, if_def.o_busy}, 9'd1);
    drive(0, 1'b1, 32);
    chk("glitch idle", {8'd0, if_def.o_busy}, 9'd0);
    check_pending("glitch");
    $display("idle glitch sequence done");

    // Low stop bit followed by a 40-bit break.
    send_frame(0, 9'h0F0, 1'b0, 1'b0, 1'b0, -1);
    exp_q.push_back('{0, 9'h0F0, 1'b0, 1'b1});
    drive(0, 1'b0, 16 * 40);
    check_pending("break");
    chk("break busy", {8'd0, if_def.o_busy}, 9'd1);
    drive(0, 1'b1, 32);
    chk("break release", {8'd0, if_def.o_busy}, 9'd0);
    send_frame(0, 9'h081, 1'b0, 1'b1, 1'b1, -1);
    exp_q.push_back('{0, 9'h081, 1'b0, 1'b0});
    drive(0, 1'b1, 32);
    check_pending("after break");
    $display("break sequence done");

    // Reset after the 4th data bit abandons the frame.
    drive(0, 1'b0, 16);
    for (int i = 0; i < 4; i++) drive(0, ((8'h3C >> i) & 8'h01) != 8'h00, 16);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rx[0] = 1'b1;
    chk("midreset data",  {1'b0, if_def.o_data}, 9'h000);
    chk("midreset valid", {8'd0, if_def.o_valid}, 9'd0);
    chk("midreset flags", {7'd0, if_def.o_parity_err, if_def.o_frame_err}, 9'd0);
    chk("midreset busy",  {8'd0, if_def.o_busy}, 9'd0);
    drive(0, 1'b1, 32);
    check_pending("midreset");
    send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1, -1);
    exp_q.push_back('{0, 9'h0C3, 1'b0, 1'b0});
    drive(0, 1'b1, 32);
    check_pending("post reset");
    $display("mid-frame reset sequence done");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver for the serial link datapath, the successor to the fixed 8N1 receiver.
- Samples an oversampled asynchronous line using the shared baud-rate tick generator.
- Adds configurable data width, optional parity, one or two stop bits, input synchronisation, 3-sample majority voting, error flags and break/idle recovery.
- Delivers each received word to the downstream interface/ALU controller as a one-cycle valid pulse.

Parameters:
NB_DATA, 8, data bits per frame; legal range 5..9.
N_TICKS, 16, i_tick pulses per bit period; even, >= 8.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN = 0.
NB_STOP, 1, number of stop bits; 1 or 2.

Ports:
i_clk  in  1  system clock, all logic on its rising edge
i_reset  in  1  synchronous, active-high reset
i_tick  in  1  one-i_clk-wide oversampling strobe, N_TICKS per bit
i_rx_data  in  1  asynchronous serial line, idle high
o_data  out  NB_DATA  last received word, LSB = first data bit received
o_valid  out  1  one-cycle pulse, frame complete
o_parity_err  out  1  parity mismatch in the frame; qualified by o_valid
o_frame_err  out  1  a stop bit was sampled low; qualified by o_valid
o_busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (i_clk and i_reset decided as above): 2-flop synchroniser loads 1; FSM goes to IDLE; tick counter and bit counter clear to 0; o_data, o_valid, o_parity_err, o_frame_err and o_busy are 0.
- A reset mid-frame abandons the frame with no o_valid.
- The FSM acts only on i_clk edges where i_tick = 1. Exception: DONE is left on the next i_clk edge.
- All line decisions use the synchronised line (2-cycle latency); i_rx_data is never used raw.
- Tick counter width: $clog2(N_TICKS). Bit counter width: $clog2(NB_DATA+1).
- IDLE: on a tick with the synced line = 0, clear the tick counter and go to START.
- START: count ticks. When the counter reaches N_TICKS/2-1, check the line:
  - line = 1: false start, return to IDLE.
  - line = 0: clear the counter, go to DATA. The counter is now mid-bit aligned.
- Bit sampling (DATA, PARITY, STOP): the counter runs 0..N_TICKS-1 and wraps.
  - Samples are captured on ticks at counts N_TICKS-3, N_TICKS-2 and N_TICKS-1.
  - Bit value = majority of the 3 samples, resolved at count N_TICKS-1.
- DATA: each resolved bit shifts in LSB-first. After the bit counter reaches NB_DATA, go to PARITY if PARITY_EN = 1, else STOP.
- PARITY: the resolved bit is compared with the XOR of the data bits, inverted when PARITY_ODD = 1. A mismatch latches the internal parity-error flag. Then go to STOP.
- STOP: NB_STOP bits are resolved. Any stop bit resolving 0 sets the internal frame-error flag. After the last stop bit resolves, go to DONE. With a frame error the last stop bit is not waited past: DONE is entered immediately.
- DONE (exactly one i_clk cycle):
  - o_valid = 1; o_data is loaded with the assembled word.
  - o_parity_err and o_frame_err present the frame flags; outside DONE they are 0.
  - Next state: WAIT_IDLE if there was a frame error, else IDLE.
- WAIT_IDLE: covers break and stuck-low lines. Stay until the synced line = 1 on a tick, then go to IDLE. A low line never generates further frames.
- o_data holds its value between valid pulses.
- A line edge during a bit period has no effect except through the majority vote.
- The end-of-frame to next-start gap may be 0 ticks: IDLE detects a start on the first low tick after DONE.

Test Plan:
1. Defaults (8N1, N_TICKS=16, tick every 4 clocks). Send 0xA5 then 0x3C back-to-back -> two o_valid pulses; o_data = 0xA5 then 0x3C; both error flags 0.
2. PARITY_EN=1, PARITY_ODD=0. Send 0x55 with parity bit 0, then 0x55 with parity bit 1 -> first frame o_parity_err=0, second o_parity_err=1; o_data = 0x55 both times.
3. Glitch low for 3 ticks on an idle line -> START aborts, no o_valid, o_busy returns to 0. Then a 1-tick low glitch mid-bit inside a valid 0x0F frame -> majority vote rejects it, o_data = 0x0F.
4. Stop bit driven low, then the line held low for 40 bit periods (break) -> exactly one o_valid with o_frame_err=1. No further o_valid until the line returns high. The next 0x81 frame is received correctly.
5. NB_DATA=7, NB_STOP=2. Send 0x5A with the second stop bit low -> o_valid with o_frame_err=1, o_data = 0x5A.
6. Assert i_reset for one cycle after the 4th data bit -> no o_valid, all outputs 0. The following 0xC3 frame is received correctly.
